// File: rtl/rcn_pkg.sv
// Shared rcn ring word layout: field positions, word type, and small field helpers.
package rcn_pkg;

  localparam int RCN_W       = 69;
  localparam int RCN_VALID   = 68;
  localparam int RCN_REQ     = 67;
  localparam int RCN_ID_HI   = 66;
  localparam int RCN_ID_LO   = 61;
  localparam int RCN_SEQ_HI  = 60;
  localparam int RCN_SEQ_LO  = 59;
  localparam int RCN_WR      = 58;
  localparam int RCN_MASK_HI = 57;
  localparam int RCN_MASK_LO = 54;
  localparam int RCN_ADDR_HI = 53;
  localparam int RCN_ADDR_LO = 32;
  localparam int RCN_DATA_HI = 31;
  localparam int RCN_DATA_LO = 0;

  typedef logic [RCN_W-1:0] rcn_t;

  // True for a valid response word whose id matches the given endpoint.
  function automatic logic rcn_is_rsp_for(input rcn_t w, input logic [5:0] id);
    return w[RCN_VALID] && !w[RCN_REQ] && (w[RCN_ID_HI:RCN_ID_LO] == id);
  endfunction

  function automatic rcn_t rcn_stamp(input rcn_t w, input logic [5:0] id);
    rcn_t r;
    r                       = w;
    r[RCN_VALID]            = 1'b1;
    r[RCN_ID_HI:RCN_ID_LO]  = id;
    return r;
  endfunction

endpackage

// File: rtl/rcn_fifo_master.sv
// Fifo-to-ring master: 1-cycle stage + 1-cycle rcn_out inject, 1-cycle ring pass-through; holds requests at MAX_OUT outstanding or when no slot is free,
// recirculates own responses while rsp_full. RCN_FIFO_MASTER_STATS_EN enables the saturating stall_cnt.
module rcn_fifo_master
  import rcn_pkg::*;
#(
  parameter logic [5:0] MASTER_ID = 6'h01,
  parameter int         MAX_OUT   = 4
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [68:0] rcn_in,
  output logic [68:0] rcn_out,
  input  logic [68:0] req_data,
  output logic        req_pop,
  output logic [68:0] rsp_data,
  output logic        rsp_push,
  input  logic        rsp_full,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] MAX_OUT_W = MAX_OUT[3:0];

  rcn_t       r_rcn_out;
  rcn_t       r_rsp_data;
  logic       r_rsp_push;
  rcn_t       r_stage;
  logic [3:0] r_outstanding;

  logic w_stage_vld;
  logic w_capture;
  logic w_slot_free;
  logic w_inject;
  logic w_load;
  logic w_cnt_inc;
  logic w_cnt_dec;

  // The stage valid bit doubles as the stored word's own valid bit.
  assign w_stage_vld = r_stage[RCN_VALID];
  assign w_capture   = rcn_is_rsp_for(rcn_in, MASTER_ID) && !rsp_full;
  assign w_slot_free = !rcn_in[RCN_VALID] || w_capture;
  assign w_inject    = w_slot_free && w_stage_vld &&
                       (!r_stage[RCN_REQ] || (r_outstanding < MAX_OUT_W));
  assign w_load      = req_data[RCN_VALID] && (!w_stage_vld || w_inject);

  // Stray responses (nothing outstanding) are still captured but not counted.
  assign w_cnt_inc = w_inject && r_stage[RCN_REQ];
  assign w_cnt_dec = w_capture && (r_outstanding != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcn_out     <= '0;
      r_rsp_data    <= '0;
      r_rsp_push    <= 1'b0;
      r_stage       <= '0;
      r_outstanding <= 4'd0;
    end else begin
      r_rsp_push <= w_capture;
      if (w_capture) begin
        r_rsp_data <= rcn_in;
      end

      if (w_inject) begin
        r_rcn_out <= rcn_stamp(r_stage, MASTER_ID);
      end else if (w_capture) begin
        r_rcn_out <= '0;
      end else begin
        r_rcn_out <= rcn_in;
      end

      if (w_load) begin
        r_stage <= req_data;
      end else if (w_inject) begin
        r_stage[RCN_VALID] <= 1'b0;
      end

      case ({w_cnt_inc, w_cnt_dec})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

`ifdef RCN_FIFO_MASTER_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stage_vld && !w_inject && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'd0;
`endif

  // Pop is gated by reset so the fifo is never drained while the stage is held clear.
  assign req_pop  = w_load && !rst;
  assign rcn_out  = r_rcn_out;
  assign rsp_data = r_rsp_data;
  assign rsp_push = r_rsp_push;
  assign busy     = w_stage_vld || (r_outstanding != 4'd0);

endmodule

// File: tb/tb_rcn_fifo_master.sv
// Directed bench for rcn_fifo_master with a queue-based request fifo model.
module tb_rcn_fifo_master;

  logic        clk;
  logic        rst;
  logic [68:0] rcn_in;
  logic [68:0] rcn_out;
  logic [68:0] req_data;
  logic        req_pop;
  logic [68:0] rsp_data;
  logic        rsp_push;
  logic        rsp_full;
  logic        busy;
  logic [15:0] stall_cnt;

  int checks;
  int errors;
  int pops;
  logic [68:0] fifo_q[$];

  rcn_fifo_master #(.MASTER_ID(6'h01), .MAX_OUT(4)) dut (
    .rst       (rst),
    .clk       (clk),
    .rcn_in    (rcn_in),
    .rcn_out   (rcn_out),
    .req_data  (req_data),
    .req_pop   (req_pop),
    .rsp_data  (rsp_data),
    .rsp_push  (rsp_push),
    .rsp_full  (rsp_full),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [68:0] mk(input logic v, input logic rq, input logic [5:0] id,
                                     input logic [1:0] seq, input logic wr, input logic [3:0] mask,
                                     input logic [21:0] addr, input logic [31:0] data);
    return {v, rq, id, seq, wr, mask, addr, data};
  endfunction

  function automatic void refresh();
    req_data = (fifo_q.size() > 0) ? fifo_q[0] : 69'd0;
  endfunction

  // Advance one clock: the fifo model pops on a req_pop seen just before the edge.
  task automatic tick();
    logic p;
    logic [68:0] dummy;
    @(negedge clk);
    p = req_pop;
    @(posedge clk);
    #1;
    if (p && fifo_q.size() > 0) begin
      dummy = fifo_q.pop_front();
      pops++;
    end
    refresh();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rcn_in   = '0;
    rsp_full = 1'b0;
    fifo_q.delete();
    refresh();
    pops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rcn_in   = mk(1, 1, 6'h05, 2'd0, 1'b0, 4'h1, 22'h1, 32'h1);
    rsp_full = 1'b0;
    req_data = mk(1, 1, 6'h00, 2'd0, 1'b0, 4'h1, 22'h2, 32'h2);
    @(posedge clk);
    #2;
    checks++; if (rcn_out !== 69'd0) begin errors++; $display("FAIL reset_rcn_out got %h want 0", rcn_out); end
    checks++; if (rsp_data !== 69'd0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    checks++; if (rsp_push !== 1'b0) begin errors++; $display("FAIL reset_rsp_push got %b want 0", rsp_push); end
    checks++; if (req_pop !== 1'b0) begin errors++; $display("FAIL reset_req_pop got %b want 0", req_pop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    do_reset();
  endtask

  task automatic test_inject();
    logic [68:0] exp_w;
    do_reset();
    fifo_q.push_back(mk(1, 1, 6'h00, 2'd1, 1'b1, 4'hF, 22'h12345, 32'hDEADBEEF));
    refresh();
    #1;
    checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL inj_pop got %b want 1", req_pop); end
    tick();
    checks++; if (rcn_out !== 69'd0) begin errors++; $display("FAIL inj_early got %h want 0", rcn_out); end
    tick();
    exp_w = mk(1, 1, 6'h01, 2'd1, 1'b1, 4'hF, 22'h12345, 32'hDEADBEEF);
    checks++; if (rcn_out !== exp_w) begin errors++; $display("FAIL inj_word got %h want %h", rcn_out, exp_w); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inj_busy got %b want 1", busy); end
    checks++; if (dut.r_outstanding !== 4'd1) begin errors++; $display("FAIL inj_out got %0d want 1", dut.r_outstanding); end
    tick();
    tick();
    checks++; if (pops !== 1) begin errors++; $display("FAIL inj_pops got %0d want 1", pops); end
    checks++; if (rcn_out !== 69'd0) begin errors++; $display("FAIL inj_after got %h want 0", rcn_out); end
  endtask

  // Continues from test_inject with one request outstanding.
  task automatic test_capture();
    logic [68:0] rsp_w;
    rsp_w  = mk(1, 0, 6'h01, 2'd1, 1'b1, 4'hF, 22'h12345, 32'hCAFEF00D);
    rcn_in = rsp_w;
    tick();
    rcn_in = '0;
    checks++; if (rsp_push !== 1'b1) begin errors++; $display("FAIL cap_push got %b want 1", rsp_push); end
    checks++; if (rsp_data !== rsp_w) begin errors++; $display("FAIL cap_data got %h want %h", rsp_data, rsp_w); end
    checks++; if (rcn_out !== 69'd0) begin errors++; $display("FAIL cap_slot got %h want 0", rcn_out); end
    checks++; if (dut.r_outstanding !== 4'd0) begin errors++; $display("FAIL cap_out got %0d want 0", dut.r_outstanding); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cap_busy got %b want 0", busy); end
    tick();
    checks++; if (rsp_push !== 1'b0) begin errors++; $display("FAIL cap_push_pulse got %b want 0", rsp_push); end
  endtask

  task automatic test_rsp_full();
    logic [68:0] rsp_w;
    do_reset();
    rsp_w    = mk(1, 0, 6'h01, 2'd2, 1'b0, 4'h3, 22'h00ABC, 32'h55AA55AA);
    rsp_full = 1'b1;
    rcn_in   = rsp_w;
    tick();
    checks++; if (rcn_out !== rsp_w) begin errors++; $display("FAIL full_pass got %h want %h", rcn_out, rsp_w); end
    checks++; if (rsp_push !== 1'b0) begin errors++; $display("FAIL full_push got %b want 0", rsp_push); end
    rsp_full = 1'b0;
    tick();
    rcn_in = '0;
    checks++; if (rsp_push !== 1'b1) begin errors++; $display("FAIL full_second_push got %b want 1", rsp_push); end
    checks++; if (rsp_data !== rsp_w) begin errors++; $display("FAIL full_second_data got %h want %h", rsp_data, rsp_w); end
    checks++; if (rcn_out !== 69'd0) begin errors++; $display("FAIL full_second_slot got %h want 0", rcn_out); end
    checks++; if (dut.r_outstanding !== 4'd0) begin errors++; $display("FAIL stray_out got %0d want 0", dut.r_outstanding); end
  endtask

  task automatic test_back_to_back();
    logic [68:0] exp_w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(mk(1, 1, 6'h00, 2'(i), 1'b0, 4'hF, 22'(i + 16), 32'(32'h100 + i)));
    end
    // A fifo-sourced response rides along and must not count.
    fifo_q.push_back(mk(1, 0, 6'h00, 2'd3, 1'b0, 4'hF, 22'h3F, 32'h77));
    refresh();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_w = mk(1, 1, 6'h01, 2'(i), 1'b0, 4'hF, 22'(i + 16), 32'(32'h100 + i));
      checks++; if (rcn_out !== exp_w) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, rcn_out, exp_w); end
    end
    tick();
    exp_w = mk(1, 0, 6'h01, 2'd3, 1'b0, 4'hF, 22'h3F, 32'h77);
    checks++; if (rcn_out !== exp_w) begin errors++; $display("FAIL b2b_rsp got %h want %h", rcn_out, exp_w); end
    checks++; if (dut.r_outstanding !== 4'd3) begin errors++; $display("FAIL b2b_out got %0d want 3", dut.r_outstanding); end
  endtask

  task automatic test_max_out();
    int inj;
    logic [68:0] exp_w;
    do_reset();
    inj = 0;
    for (int i = 0; i < 6; i++) begin
      fifo_q.push_back(mk(1, 1, 6'h00, 2'd0, 1'b1, 4'hF, 22'(i), 32'(32'hA0 + i)));
    end
    refresh();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rcn_out[68] && rcn_out[67]) inj++;
    end
    checks++; if (inj !== 4) begin errors++; $display("FAIL max_inj got %0d want 4", inj); end
    checks++; if (pops !== 5) begin errors++; $display("FAIL max_pops got %0d want 5", pops); end
    checks++; if (fifo_q.size() !== 1) begin errors++; $display("FAIL max_fifo got %0d want 1", fifo_q.size()); end
    checks++; if (req_pop !== 1'b0) begin errors++; $display("FAIL max_pop_low got %b want 0", req_pop); end
    checks++; if (dut.r_outstanding !== 4'd4) begin errors++; $display("FAIL max_out got %0d want 4", dut.r_outstanding); end
    rcn_in = mk(1, 0, 6'h01, 2'd0, 1'b1, 4'hF, 22'h0, 32'h0);
    tick();
    rcn_in = '0;
    checks++; if (rsp_push !== 1'b1) begin errors++; $display("FAIL max_rsp_push got %b want 1", rsp_push); end
    checks++; if (rcn_out !== 69'd0) begin errors++; $display("FAIL max_rsp_slot got %h want 0", rcn_out); end
    tick();
    exp_w = mk(1, 1, 6'h01, 2'd0, 1'b1, 4'hF, 22'd4, 32'hA4);
    checks++; if (rcn_out !== exp_w) begin errors++; $display("FAIL max_fifth got %h want %h", rcn_out, exp_w); end
  endtask

  task automatic test_stall();
    logic [68:0] f;
    logic [68:0] exp_w;
    logic [15:0] exp_stall;
    do_reset();
    fifo_q.push_back(mk(1, 1, 6'h00, 2'd2, 1'b1, 4'h5, 22'h2AAAA, 32'h13579BDF));
    refresh();
    for (int k = 0; k <= 10; k++) begin
      f = (k % 2 == 0) ? mk(1, 1, 6'h05, 2'(k), 1'b0, 4'hC, 22'(k), 32'(32'hF00 + k))
                       : mk(1, 0, 6'h02, 2'(k), 1'b1, 4'h3, 22'(k), 32'(32'hE00 + k));
      rcn_in = f;
      tick();
      checks++; if (rcn_out !== f) begin errors++; $display("FAIL stall_pass%0d got %h want %h", k, rcn_out, f); end
    end
    rcn_in = '0;
`ifdef RCN_FIFO_MASTER_STATS_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
    tick();
    exp_w = mk(1, 1, 6'h01, 2'd2, 1'b1, 4'h5, 22'h2AAAA, 32'h13579BDF);
    checks++; if (rcn_out !== exp_w) begin errors++; $display("FAIL stall_inject got %h want %h", rcn_out, exp_w); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL stall_hold got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_simultaneous();
    logic [68:0] rsp_w;
    logic [68:0] exp_w;
    do_reset();
    fifo_q.push_back(mk(1, 1, 6'h00, 2'd0, 1'b0, 4'hF, 22'h10, 32'h11111111));
    fifo_q.push_back(mk(1, 1, 6'h00, 2'd1, 1'b1, 4'hF, 22'h20, 32'h22222222));
    fifo_q.push_back(mk(1, 1, 6'h00, 2'd2, 1'b1, 4'hF, 22'h30, 32'h33333333));
    refresh();
    tick();
    tick();
    checks++; if (dut.r_outstanding !== 4'd1) begin errors++; $display("FAIL sim_pre_out got %0d want 1", dut.r_outstanding); end
    rsp_w  = mk(1, 0, 6'h01, 2'd0, 1'b0, 4'hF, 22'h10, 32'h99999999);
    rcn_in = rsp_w;
    tick();
    rcn_in = mk(1, 1, 6'h07, 2'd0, 1'b0, 4'h1, 22'h5, 32'h5);
    exp_w  = mk(1, 1, 6'h01, 2'd1, 1'b1, 4'hF, 22'h20, 32'h22222222);
    checks++; if (rcn_out !== exp_w) begin errors++; $display("FAIL sim_inject got %h want %h", rcn_out, exp_w); end
    checks++; if (rsp_push !== 1'b1) begin errors++; $display("FAIL sim_push got %b want 1", rsp_push); end
    checks++; if (rsp_data !== rsp_w) begin errors++; $display("FAIL sim_data got %h want %h", rsp_data, rsp_w); end
    checks++; if (dut.r_outstanding !== 4'd1) begin errors++; $display("FAIL sim_out got %0d want 1", dut.r_outstanding); end
    // Reset in the middle of traffic with the stage full and the ring busy.
    tick();
    rst = 1'b1;
    #1;
    checks++; if (rcn_out !== 69'd0) begin errors++; $display("FAIL mid_rst_rcn_out got %h want 0", rcn_out); end
    checks++; if (rsp_data !== 69'd0) begin errors++; $display("FAIL mid_rst_rsp_data got %h want 0", rsp_data); end
    checks++; if (rsp_push !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_push got %b want 0", rsp_push); end
    checks++; if (req_pop !== 1'b0) begin errors++; $display("FAIL mid_rst_req_pop got %b want 0", req_pop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_stall got %0d want 0", stall_cnt); end
    do_reset();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pops     = 0;
    rst      = 1'b1;
    rcn_in   = '0;
    req_data = '0;
    rsp_full = 1'b0;
    test_reset();
    test_inject();
    test_capture();
    test_rsp_full();
    test_back_to_back();
    test_max_out();
    test_stall();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rcn_fifo_master.md
Name: rcn_fifo_master

Overview:
- Single-clock rcn ring endpoint on the read side of an rcn transaction fifo.
- Pops request transactions from the fifo read port and inserts them into free ring slots, stamping the source id with MASTER_ID.
- Removes responses addressed to MASTER_ID from the ring and pushes them to a response fifo write port.
- Bounds in-flight requests with an outstanding counter; this is the standard consumer for fifo-crossed traffic entering a ring.

Parameters:
- MASTER_ID, 6'h01, id stamped into injected requests and matched on returning responses.
- MAX_OUT, 4, maximum outstanding requests (1..15).

Ports:
- rst  in  1  asynchronous reset, active-high.
- clk  in  1  clock, all logic on rising edge.
- rcn_in  in  69  ring from upstream node.
- rcn_out  out  69  ring to downstream node, registered.
- req_data  in  69  fifo read data; bit 68 = fifo not empty.
- req_pop  out  1  fifo pop, one pulse per accepted word.
- rsp_data  out  69  captured response, registered.
- rsp_push  out  1  response push, one-cycle pulse.
- rsp_full  in  1  response fifo full.
- busy  out  1  stage valid or outstanding != 0.
- stall_cnt  out  16  blocked-injection cycle count (see Optional Feature).

Behaviour:
- Rcn word fields: [68] valid, [67] req, [66:61] id, [60:59] seq, [58] wr, [57:54] mask, [53:32] addr[23:2], [31:0] data.
- Reset values: rcn_out=0, rsp_data=0, rsp_push=0, req_pop=0, stage empty, outstanding=0, stall_cnt=0. Reset mid-operation discards the stage and any in-flight count.
- Capture, evaluated each cycle: rcn_in[68] & !rcn_in[67] & rcn_in[66:61]==MASTER_ID & !rsp_full.
  - Next edge: rsp_data<=rcn_in, rsp_push=1, and the slot is treated as free.
  - If rsp_full=1, the response passes downstream unchanged and recirculates.
- Slot free = !rcn_in[68] | capture.
- Inject: slot free & stage valid & (stage[67]==0 | outstanding<MAX_OUT).
  - rcn_out <= stage with [66:61] replaced by MASTER_ID, valid=1.
  - Stage clears.
- Otherwise: rcn_out <= capture ? 69'd0 : rcn_in.
  - Ring pass-through latency is 1 cycle.
  - Foreign traffic is never modified.
- Stage load: when req_data[68] & (stage empty | inject this cycle), load the stage with req_data and drive req_pop=1 combinationally in that cycle.
  - req_pop is never asserted when req_data[68]=0.
  - Minimum fifo-to-ring latency is 1 cycle in stage plus 1 cycle in rcn_out.
  - Back-to-back injection sustains 1 word/cycle on an empty ring.
- Outstanding counter, 4 bits:
  - +1 on inject with stage[67]=1.
  - -1 on capture.
  - Simultaneous inject and capture: unchanged.
  - Never wraps. At MAX_OUT, requests hold in the stage and the fifo is not popped.
- Responses with stage[67]=0 in the stage (fifo-sourced responses) inject without counting.
- Capture while outstanding==0 (stray response): captured and pushed, counter stays 0.
- busy is combinational from the stage and the counter.

Optional Feature:
- RCN_FIFO_MASTER_STATS_EN defined: stall_cnt increments each cycle the stage is valid but inject is false.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: stall_cnt is tied to 16'd0 and no counter logic is generated. The port exists in both builds.

Decomposition:
- Shared package rcn_pkg holds:
  - RCN_W=69.
  - Field position constants RCN_VALID=68, RCN_REQ=67, RCN_ID_HI=66, RCN_ID_LO=61, RCN_SEQ, RCN_WR, RCN_MASK, RCN_ADDR, RCN_DATA ranges.
  - Typedef rcn_t (69-bit).
- Sub-module: none required. The stage register, slot arbitration and counter remain in one module.

Test Plan:
- Empty ring, fifo holds one request (id field 0) → req_pop pulses once; 2 cycles later rcn_out valid with id=6'h01 and all other fields equal; outstanding=1, busy=1.
- Response id=6'h01 on rcn_in, rsp_full=0 → rsp_push pulse next edge, rsp_data equals input, rcn_out=0 that cycle, outstanding decrements.
- Same response with rsp_full=1 → rcn_out equals rcn_in after 1 cycle, no rsp_push. Release rsp_full on the second pass → captured.
- MAX_OUT=4, issue 6 requests with no responses → exactly 4 injected, 5th held in stage, 6th stays in fifo (req_pop low). Return one response → 5th injected next cycle.
- Ring fully occupied by foreign traffic for 10 cycles with stage valid → pass-through intact. stall_cnt=10 with RCN_FIFO_MASTER_STATS_EN, 0 without. Free slot → inject.
- Capture and pending request in the same cycle → response pushed, request injected into the freed slot, outstanding unchanged. Assert rst mid-stream → all outputs 0 immediately.
